div_iter: RTL and testbench

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU group, placed in the execute backend beside the ALU's `cla_adder`. It performs subtraction, the inverse of the adder path: restoring division retires one quotient bit per cycle through a `cla_adder` trial subtractor. It takes one operation at a time under a valid/ready handshake and holds its result until the consumer accepts it.

---
 rtl/div_iter_pkg.sv | 26 ++
 rtl/div_iter_cla.sv | 92 +++++++++
 rtl/div_iter.sv | 170 +++++++++++++++++
 tb/tb_div_iter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared types for the iterative divider: op encodings, FSM states and op decode helpers.
package div_iter_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_iter_cla.sv
// Carry-lookahead adders used by the divider: cla_adder_ci exposes carry-in,
// cla_adder is the same adder with carry-in tied low.
module cla_adder_ci #(
  parameter int    W  = 32,
  parameter string ST = "hybird"
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum
);

  if (ST == "BK") begin : g_bk
    // Brent-Kung prefix over the low W-1 bits; those are the only carries the sum needs.
    localparam int N1  = W - 1;
    localparam int TOP = (N1 > 1) ? (1 << ($clog2(N1) - 1)) : 1;

    always_comb begin : prefix
      logic [W-1:0]  pr;
      logic [N1-1:0] gg;
      logic [N1-1:0] pp;
      logic [W-1:0]  c;
      pr = a ^ b;
      gg = a[N1-1:0] & b[N1-1:0];
      pp = pr[N1-1:0];
      for (int d = 1; d < N1; d = d * 2) begin
        for (int i = 2 * d - 1; i < N1; i = i + 2 * d) begin
          gg[i] = gg[i] | (pp[i] & gg[i-d]);
          pp[i] = pp[i] & pp[i-d];
        end
      end
      for (int d = TOP; d >= 1; d = d / 2) begin
        for (int i = 3 * d - 1; i < N1; i = i + 2 * d) begin
          gg[i] = gg[i] | (pp[i] & gg[i-d]);
          pp[i] = pp[i] & pp[i-d];
        end
      end
      c   = {gg | (pp & {N1{ci}}), ci};
      sum = pr ^ c;
    end
  end else begin : g_hybird
    // 4-bit lookahead groups; group carries ripple from one group to the next.
    always_comb begin : lookahead
      logic [W-1:0] g;
      logic [W-1:0] p;
      logic [W-1:0] c;
      logic         gacc;
      logic         pacc;
      logic         cin_grp;
      logic         carry;
      g       = a & b;
      p       = a ^ b;
      c       = '0;
      c[0]    = ci;
      gacc    = 1'b0;
      pacc    = 1'b1;
      cin_grp = ci;
      carry   = ci;
      for (int j = 0; j < W; j++) begin
        if (j % 4 == 0) begin
          cin_grp = c[j];
          gacc    = 1'b0;
          pacc    = 1'b1;
        end
        gacc  = g[j] | (p[j] & gacc);
        pacc  = pacc & p[j];
        carry = gacc | (pacc & cin_grp);
        if (j + 1 < W) c[j+1] = carry;
      end
      sum = p ^ c;
    end
  end

endmodule

module cla_adder #(
  parameter int    W  = 32,
  parameter string ST = "hybird"
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  cla_adder_ci #(.W(W), .ST(ST)) u_add (
    .a  (a),
    .b  (b),
    .ci (1'b0),
    .sum(sum)
  );

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle, sign fix-up afterwards, result held under a valid/ready handshake.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int    NUM = 32,
  parameter string ST  = "hybird"
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [NUM-1:0] a,
  input  logic [NUM-1:0] b,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [NUM-1:0] result
);

  localparam int             CW       = $clog2(NUM) + 1;
  localparam logic [NUM-1:0] ALL_ONES = '1;
  localparam logic [NUM-1:0] MIN_INT  = {1'b1, {(NUM-1){1'b0}}};
  localparam logic [CW-1:0]  ITERS    = CW'(NUM);

  state_e         state_q, state_d;
  logic           rem_op_q, rem_op_d;
  logic           a_neg_q, a_neg_d;
  logic           q_neg_q, q_neg_d;
  logic [NUM-1:0] rem_q, rem_d;
  logic [NUM-1:0] quo_q, quo_d;
  logic [NUM:0]   divn_q, divn_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NUM-1:0] result_q, result_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic           accept;
  logic           sgn;
  logic [NUM:0]   trial;
  logic [NUM:0]   divb_sum;
  logic [NUM-1:0] neg_in;
  logic [NUM-1:0] neg_sum;
  logic [NUM-1:0] fix_val;
  logic           fix_neg;

  assign accept  = in_valid && in_ready_q && !flush;
  assign sgn     = op_is_signed(op);
  assign fix_val = rem_op_q ? rem_q : quo_q;
  assign fix_neg = rem_op_q ? a_neg_q : q_neg_q;
  // One negator serves both the dividend on entry and the result in FIX.
  assign neg_in  = (state_q == FIX) ? ~fix_val : ~a;

  cla_adder #(.W(NUM + 1), .ST(ST)) u_trial (
    .a  ({rem_q, quo_q[NUM-1]}),
    .b  (divn_q),
    .sum(trial)
  );

  cla_adder_ci #(.W(NUM), .ST(ST)) u_neg (
    .a  (neg_in),
    .b  ('0),
    .ci (1'b1),
    .sum(neg_sum)
  );

  cla_adder_ci #(.W(NUM + 1), .ST(ST)) u_divneg (
    .a  (~{1'b0, b}),
    .b  ('0),
    .ci (1'b1),
    .sum(divb_sum)
  );

  always_comb begin
    state_d  = state_q;
    rem_op_d = rem_op_q;
    a_neg_d  = a_neg_q;
    q_neg_d  = q_neg_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    divn_d   = divn_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rem_op_d = op_is_rem(op);
          a_neg_d  = sgn && a[NUM-1];
          q_neg_d  = sgn && (a[NUM-1] ^ b[NUM-1]);
          rem_d    = '0;
          quo_d    = (sgn && a[NUM-1]) ? neg_sum : a;
          // A negative signed divisor sign-extended is already -|b| in NUM+1 bits.
          divn_d   = (sgn && b[NUM-1]) ? {1'b1, b} : divb_sum;
          cnt_d    = ITERS;
          if (b == '0) begin
            state_d  = DONE;
            result_d = op_is_rem(op) ? a : ALL_ONES;
          end else if (sgn && (a == MIN_INT) && (b == ALL_ONES)) begin
            state_d  = DONE;
            result_d = op_is_rem(op) ? '0 : MIN_INT;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[NUM]) begin
          rem_d = trial[NUM-1:0];
          quo_d = {quo_q[NUM-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[NUM-2:0], quo_q[NUM-1]};
          quo_d = {quo_q[NUM-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_neg ? neg_sum : fix_val;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_op_q    <= 1'b0;
      a_neg_q     <= 1'b0;
      q_neg_q     <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      divn_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_op_q    <= rem_op_d;
      a_neg_q     <= a_neg_d;
      q_neg_q     <= q_neg_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divn_q      <= divn_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: driver pushes expected results from a plain
// arithmetic reference model, a separate monitor pops and compares them.
module tb_div_iter;

  localparam int NUM = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_accept = 0;
  int ready_mode = 1;

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
  } vec_t;

  exp_t exp_q[$];
  vec_t dir_v[$];

  div_iter #(.NUM(NUM), .ST("hybird")) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit isSpecial(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) || (!o[0] && x == MIN_INT && y == 32'hFFFF_FFFF);
  endfunction

  // RV32M semantics straight from the arithmetic operators.
  function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx;
    int sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == MIN_INT && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : MIN_INT;
    if (o[0]) return o[1] ? (x % y) : (x / y);
    return o[1] ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                               input bit push, input bit use_exp, input logic [31:0] exp_i);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    op = op_i;
    a = a_i;
    b = b_i;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL in_ready_timeout: in_ready low for %0d cycles, required 1", waited);
      in_valid = 1'b0;
      return;
    end
    last_accept = cyc;
    if (push) begin
      e.res = use_exp ? exp_i : refModel(op_i, a_i, b_i);
      e.acc_cyc = cyc;
      e.lat = isSpecial(op_i, a_i, b_i) ? 1 : NUM + 2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input int max_cyc);
    int n;
    n = 0;
    while (!out_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL out_valid_timeout: out_valid low for %0d cycles, required 1", n);
    end
  endtask

  task automatic waitIdle(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin : ready_gen
    forever begin
      @(negedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    logic        prev_valid;
    logic [31:0] held;
    exp_t        e;
    prev_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("result", result, e.res);
          checkOutput("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
        held = result;
      end else if (out_valid && prev_valid) begin
        checkOutput("result_stable", result, held);
      end
      prev_valid = out_valid;
    end
  end

  initial begin : main
    int t0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;

    dir_v.push_back('{2'b01, 32'd100, 32'd7, 32'd14});
    dir_v.push_back('{2'b11, 32'd100, 32'd7, 32'd2});
    dir_v.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    dir_v.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    dir_v.push_back('{2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF});
    dir_v.push_back('{2'b10, 32'd5, 32'd0, 32'd5});
    dir_v.push_back('{2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF});
    dir_v.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    dir_v.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    ready_mode = 1;
    foreach (dir_v[i]) applyStimulus(dir_v[i].o, dir_v[i].x, dir_v[i].y, 1'b1, 1'b1, dir_v[i].r);

    // Back-to-back throughput with out_ready high.
    applyStimulus(2'b01, 32'd12345, 32'd17, 1'b1, 1'b0, 32'd0);
    t0 = last_accept;
    applyStimulus(2'b00, 32'hFFFF_0000, 32'd3, 1'b1, 1'b0, 32'd0);
    checkOutput("throughput", 32'(last_accept - t0), 32'(NUM + 3));
    waitIdle(200);

    // Backpressure in DONE.
    @(negedge clk);
    ready_mode = 2;
    applyStimulus(2'b01, 32'd100, 32'd7, 1'b1, 1'b1, 32'd14);
    waitOutValid(60);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_result", result, 32'd14);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    ready_mode = 1;
    @(negedge clk);
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush mid-CALC, then flush together with a request in IDLE.
    applyStimulus(2'b00, 32'd1000, 32'd3, 1'b0, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    op = 2'b01;
    a = 32'd50;
    b = 32'd5;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_no_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-operation.
    applyStimulus(2'b00, 32'hFFFF_0000, 32'd12345, 1'b0, 1'b0, 32'd0);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b01, 32'd100, 32'd7, 1'b1, 1'b1, 32'd14);
    waitIdle(200);

    // Randomized operations with random backpressure.
    ready_mode = 0;
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = MIN_INT; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 200));
        4: rb = -32'($urandom_range(1, 9));
        5: ra = MIN_INT;
        default: ;
      endcase
      applyStimulus(ro, ra, rb, 1'b1, 1'b0, 32'd0);
    end
    ready_mode = 1;
    waitIdle(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
